// File: rtl/vga_frame_capture.sv
// Rebuilds pixel coordinates from a VGA sync stream and writes a WIN_W x WIN_H
// top-left window of one frame into a 24-bit pixel RAM in raster order.
module vga_frame_capture #(
    parameter int unsigned WIN_W  = 180,
    parameter int unsigned WIN_H  = 180,
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              blank_b,
    input  logic [7:0]        r,
    input  logic [7:0]        g,
    input  logic [7:0]        b,
    input  logic              capture_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              short_frame
);

    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] X_LAST  = CW'(WIN_W - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(WIN_H - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       x_q, x_d;
    logic [CW-1:0]       y_q, y_d;
    logic                line_act_q, line_act_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [23:0]         wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                short_q, short_d;

    logic hfall_c;
    logic vfall_c;
    logic in_win_c;
    logic last_pix_c;

    assign hfall_c    = hs_q & ~hsync;
    assign vfall_c    = vs_q & ~vsync;
    assign in_win_c   = blank_b & (x_q <= X_LAST) & (y_q <= Y_LAST);
    assign last_pix_c = (x_q == X_LAST) & (y_q == Y_LAST);

    // Coordinate recovery: vfall beats hfall; y only advances after a line that had active pixels.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        line_act_d = line_act_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        if (pix_en) begin
            hs_d = hsync;
            vs_d = vsync;
            if (vfall_c) begin
                x_d        = '0;
                y_d        = '0;
                line_act_d = 1'b0;
            end else if (hfall_c) begin
                x_d = '0;
                if (line_act_q) begin
                    y_d        = (y_q == CNT_MAX) ? y_q : y_q + CW'(1);
                    line_act_d = 1'b0;
                end
            end else if (blank_b) begin
                x_d        = (x_q == CNT_MAX) ? x_q : x_q + CW'(1);
                line_act_d = 1'b1;
            end
        end
    end

    // Capture FSM and RAM write port.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        short_d   = short_q;
        case (state_q)
            S_IDLE: begin
                if (capture_req) begin
                    state_d = S_ARM;
                    short_d = 1'b0;
                    addr_d  = '0;
                end
            end
            S_ARM: begin
                if (pix_en && vfall_c) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (pix_en) begin
                    if (vfall_c) begin
                        short_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (in_win_c) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {b, g, r};
                        addr_d    = addr_q + ADDR_W'(1);
                        if (last_pix_c) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            line_act_q <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_act_q <= line_act_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            short_q    <= short_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign short_frame = short_q;

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Sink-side counterpart of the VGA timing/video generator: consumes a 640x480 VGA pixel stream (active-low hsync/vsync, blank_b, 8-bit r/g/b).
- Rebuilds pixel coordinates from the sync signals alone and writes a WIN_W x WIN_H top-left window of one frame into a 24-bit pixel RAM.
- The RAM uses the same {b,g,r} packing and raster address order that the image ROM uses.
- Used for loopback self-test of the display path and for frame grabbing into the image memory.

Parameters:
WIN_W, 180, captured window width in pixels (1..640)
WIN_H, 180, captured window height in lines (1..480)
ADDR_W, 24, write address width

Ports:
clk  in  1  system clock (2x pixel rate)
reset  in  1  synchronous, active-high reset
pix_en  in  1  pixel strobe, one clk cycle per pixel (vgaclk rising-edge equivalent)
hsync  in  1  horizontal sync, active low
vsync  in  1  vertical sync, active low
blank_b  in  1  1 = active display pixel
r  in  8  red
g  in  8  green
b  in  8  blue
capture_req  in  1  single-cycle request to grab the next full frame
wr_en  out  1  pixel RAM write strobe
wr_addr  out  ADDR_W  pixel RAM address, raster order from 0
wr_data  out  24  {b,g,r}: r in [7:0], g in [15:8], b in [23:16]
busy  out  1  high in ARM and CAPTURE
done  out  1  one-cycle pulse, full window written
short_frame  out  1  sticky: frame ended before window complete; cleared by reset or by an accepted capture_req

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0, short_frame=0.
  - x=0, y=0, line_act=0, hs_d=1, vs_d=1, state=IDLE.
- All inputs except capture_req and reset are sampled only on cycles with pix_en=1; with pix_en=0, counters and edge registers hold.
- Edge detection:
  - hs_d and vs_d hold the previously sampled sync levels.
  - hfall = hs_d & ~hsync; vfall = vs_d & ~vsync.
- Coordinate counters (10 bits, per pix_en):
  - vfall: x<=0, y<=0, line_act<=0 (vfall has priority over hfall in the same sample).
  - Else if hfall: x<=0. If line_act: y<=y+1 (saturate at 1023) and line_act<=0.
  - Else if blank_b: x<=x+1 (saturate at 1023) and line_act<=1.
- The pixel at (x,y) is the one sampled with blank_b=1 before x increments.
- in_win = blank_b & (x<WIN_W) & (y<WIN_H).
- FSM states: IDLE, ARM, CAPTURE, DONE.
  - IDLE: capture_req -> ARM; short_frame<=0 and the address counter is cleared to 0.
  - ARM: wait for vfall -> CAPTURE. Pixels seen before the first vfall are never written, even if in_win.
  - CAPTURE: on each pix_en with in_win:
    - Next cycle: wr_en=1, wr_data={b,g,r}, wr_addr=address counter.
    - The address counter then increments, so addresses run 0..WIN_W*WIN_H-1 contiguously, without a multiplier.
    - After writing (x==WIN_W-1, y==WIN_H-1) -> DONE.
  - CAPTURE, vfall before the last pixel: short_frame<=1 -> IDLE; no further writes.
  - DONE: done=1 for exactly one clk -> IDLE.
- Latency: exactly one clk from the sampling pix_en cycle to wr_en. wr_en is otherwise 0 and is never high two cycles in a row.
- wr_addr and wr_data hold their last values while wr_en=0.
- capture_req in ARM, CAPTURE or DONE is ignored (no restart, no queueing).
- capture_req and reset in the same cycle: reset wins.
- Reset mid-capture:
  - Next cycle wr_en=0 and state=IDLE.
  - A partially written window is left in RAM with no done pulse.
- Non-standard streams: no timing checks beyond the counters. Lines longer than 1023 pixels saturate x, so no writes occur beyond WIN_W.

Test Plan:
1. Full capture: reset, capture_req, drive 2 frames of 800x525 timing with pixel value {b,g,r}=addr-pattern -> exactly 32400 writes; first write wr_addr=0 with (0,0) data; last write wr_addr=32399 with (179,179) data; single done pulse; busy=0 after.
2. Arm alignment: assert capture_req mid-frame at line 200 -> no writes until the next vfall; then pixel (0,0) of the following frame lands at addr 0.
3. Short frame: WIN_H=180, assert vsync after 100 active lines -> 18000 writes, short_frame=1, done never pulses; a new capture_req clears short_frame.
4. Window edges: at x=179 and x=180 on line 0 -> write only for x=179; blanked pixels with x<180 during hsync porch -> no write.
5. Reset mid-capture: reset during line 50 -> wr_en=0 next cycle, busy=0, done=0; a subsequent capture_req followed by a full frame starts again from addr 0.
6. Ignored request and pacing: capture_req pulsed during CAPTURE -> no effect on addresses; pix_en held low for 5 cycles mid-line -> x/addr hold and no spurious writes.
